// File: rtl/demorgan_pkg.sv
// Shared types and constants for the 3-input De Morgan equivalence checker.
package demorgan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int                 NUM_VEC   = 8;
    localparam logic [2:0]         LAST_VEC  = 3'(NUM_VEC - 1);
    // Bit i is the expected d = ~((a|b)&c) for vector i = {a,b,c}.
    localparam logic [NUM_VEC-1:0] GOLDEN_TT = 8'h57;

endpackage

// File: rtl/demorgan_equiv_checker_if.sv
// Signal bundle between the checker and whatever hosts it (board logic or bench).
interface demorgan_equiv_checker_if;

    logic       start;
    logic       dut_d;
    logic       vec_a;
    logic       vec_b;
    logic       vec_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       first_fail_vld;

    modport master (
        output start, dut_d,
        input  vec_a, vec_b, vec_c, busy, done, pass,
               err_count, first_fail_vec, first_fail_vld
    );

    modport slave (
        input  start, dut_d,
        output vec_a, vec_b, vec_c, busy, done, pass,
               err_count, first_fail_vec, first_fail_vld
    );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter timing the window a stimulus vector is held before sampling.
module settle_timer #(
    parameter int               CNT_W  = 3,
    parameter logic [CNT_W-1:0] RELOAD = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= RELOAD;
        end else if (en && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expire = en && (count_q == '0);

endmodule

// File: rtl/demorgan_equiv_checker.sv
// Sweeps all eight {a,b,c} vectors into an external gate and scores its output
// against the De Morgan golden truth table.
module demorgan_equiv_checker
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    demorgan_equiv_checker_if.slave   bus
);

    state_t     state_q;
    logic [2:0] vec_q;
    logic [3:0] err_q;
    logic [2:0] ff_vec_q;
    logic       ff_vld_q;
    logic       pass_q;
    logic       done_q;
    logic       busy_q;
    logic       dut_q;

    logic load;
    logic expire;
    logic mismatch;

    // The timer reloads on the same edge that enters DRIVE.
    assign load = (state_q == IDLE && bus.start) ||
                  (state_q == SAMPLE && vec_q != LAST_VEC);

    settle_timer #(
        .CNT_W  (CNT_W),
        .RELOAD (CNT_W'(SETTLE_CYCLES - 1))
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .en     (state_q == DRIVE),
        .expire (expire)
    );

    // dut_d is re-timed through one flop; the settle window absorbs that latency.
    assign mismatch = (dut_q != GOLDEN_TT[vec_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            err_q    <= '0;
            ff_vec_q <= '0;
            ff_vld_q <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dut_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dut_q  <= bus.dut_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= DRIVE;
                        busy_q   <= 1'b1;
                        vec_q    <= '0;
                        err_q    <= '0;
                        ff_vld_q <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (expire) state_q <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_q + 4'd1;
                        if (!ff_vld_q) begin
                            ff_vld_q <= 1'b1;
                            ff_vec_q <= vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                    end else begin
                        state_q <= DRIVE;
                        vec_q   <= vec_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec_a          = vec_q[2];
    assign bus.vec_b          = vec_q[1];
    assign bus.vec_c          = vec_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ff_vec_q;
    assign bus.first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_demorgan_equiv_checker.sv
// Scoreboard bench for demorgan_equiv_checker driving a behavioural gate model.
module tb_demorgan_equiv_checker;

    localparam int SWEEP = 8 * (2 + 1);

    typedef struct {
        logic [3:0] err;
        logic       vld;
        logic [2:0] ffv;
        logic       pass;
        int         done_edge;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   mode  = 0;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    demorgan_equiv_checker_if bus_if ();

    demorgan_equiv_checker #(
        .SETTLE_CYCLES (2),
        .CNT_W         (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Device under lab test: 0 golden, 1 stuck-0, 2 stuck-1, 3 wrong law.
    always_comb begin
        case (mode)
            0:       bus_if.dut_d = ~((bus_if.vec_a | bus_if.vec_b) & bus_if.vec_c);
            1:       bus_if.dut_d = 1'b0;
            2:       bus_if.dut_d = 1'b1;
            default: bus_if.dut_d = ~bus_if.vec_a & ~bus_if.vec_b & ~bus_if.vec_c;
        endcase
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int sample_edge, input logic [3:0] err, input logic vld,
                            input logic [2:0] ffv, input logic pass);
        exp_t e;
        e.err = err; e.vld = vld; e.ffv = ffv; e.pass = pass;
        e.done_edge = sample_edge + SWEEP;
        sb_q.push_back(e);
    endtask

    // Raise start for one cycle; the expectation is tied to the edge that samples it.
    task automatic issue(input logic [3:0] err, input logic vld, input logic [2:0] ffv,
                         input logic pass);
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        push_exp(edge_cnt + 1, err, vld, ffv, pass);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check("busy_after_start", 32'(bus_if.busy), 32'd1);
        check("vec_after_start", {29'd0, bus_if.vec_a, bus_if.vec_b, bus_if.vec_c}, 32'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        check(name, 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) check("done_one_cycle", 32'(bus_if.done), 32'd0);
            if (bus_if.done) begin
                check("done_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("done_cycle", 32'(edge_cnt), 32'(mon_e.done_edge));
                    check("err_count", 32'(bus_if.err_count), 32'(mon_e.err));
                    check("pass", 32'(bus_if.pass), 32'(mon_e.pass));
                    check("first_fail_vld", 32'(bus_if.first_fail_vld), 32'(mon_e.vld));
                    if (mon_e.vld)
                        check("first_fail_vec", 32'(bus_if.first_fail_vec), 32'(mon_e.ffv));
                end
            end
        end
        prev_done <= bus_if.done;
    end

    initial begin
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_pass", 32'(bus_if.pass), 32'd0);
        check("rst_err", 32'(bus_if.err_count), 32'd0);
        check("rst_ffvld", 32'(bus_if.first_fail_vld), 32'd0);
        check("rst_ffvec", 32'(bus_if.first_fail_vec), 32'd0);
        check("rst_vec", {29'd0, bus_if.vec_a, bus_if.vec_b, bus_if.vec_c}, 32'd0);
        rst_n = 1'b1;

        // 1: golden gate
        mode = 0;
        issue(4'd0, 1'b0, 3'd0, 1'b1);
        drain("drain_golden");
        check("idle_busy", 32'(bus_if.busy), 32'd0);

        // 2: stuck at 0, results must hold after done
        mode = 1;
        issue(4'd5, 1'b1, 3'b000, 1'b0);
        drain("drain_stuck0");
        repeat (3) @(posedge clk);
        #1;
        check("hold_err", 32'(bus_if.err_count), 32'd5);
        check("hold_ffvec", 32'(bus_if.first_fail_vec), 32'd0);
        check("hold_vec", {29'd0, bus_if.vec_a, bus_if.vec_b, bus_if.vec_c}, 32'd7);

        // 3: stuck at 1
        mode = 2;
        issue(4'd3, 1'b1, 3'b011, 1'b0);
        drain("drain_stuck1");

        // 4: wrong law
        mode = 3;
        issue(4'd4, 1'b1, 3'b001, 1'b0);
        drain("drain_wronglaw");

        // 5: reset mid-sweep at cycle 10, then a clean sweep
        mode = 1;
        issue(4'd5, 1'b1, 3'b000, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_err", 32'(bus_if.err_count), 32'd0);
        check("midrst_ffvld", 32'(bus_if.first_fail_vld), 32'd0);
        check("midrst_vec", {29'd0, bus_if.vec_a, bus_if.vec_b, bus_if.vec_c}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (SWEEP + 5) @(posedge clk);
        mode = 0;
        issue(4'd0, 1'b0, 3'd0, 1'b1);
        drain("drain_after_rst");

        // 6: start at cycles 5 and 25 ignored, start at 26 launches sweep 2
        issue(4'd0, 1'b0, 3'd0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        push_exp(edge_cnt + 2, 4'd0, 1'b0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check("resweep_busy", 32'(bus_if.busy), 32'd1);
        drain("drain_resweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
